wb_commit: RTL and testbench

//  Writeback/commit stage feeding the CSR file: registers one instruction from MEM, resolves

---
 rtl/wb_commit_if.sv | 49 ++++
 rtl/wb_commit.sv | 213 +++++++++++++++++++++
 tb/tb_wb_commit.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_commit_if.sv
// Signal bundle around the writeback/commit stage: MEM-side instruction fields, the CSR file
// interface, the GPR write port and the flush/redirect outputs.
interface wb_commit_if;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_ex;
    logic [5:0]  ms_ecode;
    logic [8:0]  ms_esubcode;
    logic        ms_ertn;
    logic [13:0] ms_csr_num;
    logic        ms_csr_re;
    logic        ms_csr_we;
    logic [31:0] ms_csr_wvalue;
    logic [31:0] ms_csr_wmask;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] era_pc;
    logic [31:0] csr_rvalue;
    logic [79:0] csr_ctrl;
    logic [48:0] csr_in_bus;
    logic        flush;
    logic [31:0] flush_target;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] debug_wb_pc;

    modport slave (
        input  ms_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
        input  ms_ex, ms_ecode, ms_esubcode, ms_ertn,
        input  ms_csr_num, ms_csr_re, ms_csr_we, ms_csr_wvalue, ms_csr_wmask,
        input  has_int, ex_entry, era_pc, csr_rvalue,
        output ws_allowin, csr_ctrl, csr_in_bus, flush, flush_target,
        output rf_we, rf_waddr, rf_wdata, debug_wb_pc
    );

    modport master (
        output ms_valid, ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
        output ms_ex, ms_ecode, ms_esubcode, ms_ertn,
        output ms_csr_num, ms_csr_re, ms_csr_we, ms_csr_wvalue, ms_csr_wmask,
        output has_int, ex_entry, era_pc, csr_rvalue,
        input  ws_allowin, csr_ctrl, csr_in_bus, flush, flush_target,
        input  rf_we, rf_waddr, rf_wdata, debug_wb_pc
    );
endinterface

// File: rtl/wb_commit.sv
// Writeback/commit stage: holds one instruction for a single cycle, resolves interrupt,
// exception and ERTN precedence, drives CSR/GPR writes and redirects the pipe on a flush.
module wb_commit #(
    parameter logic [5:0] ECODE_INT = 6'h00,
    parameter int         DRAIN_CYC = 1
) (
    input  logic        clk,
    input  logic        reset,
    wb_commit_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    localparam logic [1:0] LP_DRAIN_LAST = 2'(DRAIN_CYC - 1);

    state_t      r_state;
    logic [1:0]  r_drain_cnt;

    logic        r_ws_valid;
    logic [31:0] r_pc;
    logic        r_rf_we;
    logic [4:0]  r_rf_waddr;
    logic [31:0] r_rf_wdata;
    logic        r_ex;
    logic [5:0]  r_ecode;
    logic [8:0]  r_esubcode;
    logic        r_ertn;
    logic [13:0] r_csr_num;
    logic        r_csr_re;
    logic        r_csr_we;
    logic [31:0] r_csr_wvalue;
    logic [31:0] r_csr_wmask;

    logic        w_int;
    logic        w_ex;
    logic        w_ertn;
    logic        w_flush;
    logic        w_allowin;
    logic [5:0]  w_ecode;
    logic [8:0]  w_esubcode;
    logic [31:0] w_pc;
    logic [31:0] w_flush_target;
    logic        w_rf_we;
    logic [4:0]  w_rf_waddr;
    logic [31:0] w_rf_wdata;
    logic [79:0] w_csr_ctrl;

    // Commit precedence: interrupt over carried exception over ERTN; bubbles see none of it.
    always_comb begin
        w_int      = 1'b0;
        w_ex       = 1'b0;
        w_ertn     = 1'b0;
        w_ecode    = 6'h00;
        w_esubcode = 9'h000;
        w_pc       = 32'h0;
        if (r_ws_valid) begin
            w_int  = bus.has_int;
            w_ex   = bus.has_int | r_ex;
            w_ertn = r_ertn & ~w_ex;
            w_pc   = r_pc;
            if (bus.has_int) begin
                w_ecode    = ECODE_INT;
                w_esubcode = 9'h000;
            end else begin
                w_ecode    = r_ecode;
                w_esubcode = r_esubcode;
            end
        end else begin
            w_int = 1'b0;
        end
    end

    // Redirect target and stage handshake; a flushing commit refuses the next instruction.
    always_comb begin
        w_flush        = w_ex | w_ertn;
        w_flush_target = 32'h0;
        if (w_ex) begin
            w_flush_target = bus.ex_entry;
        end else if (w_ertn) begin
            w_flush_target = bus.era_pc;
        end else begin
            w_flush_target = 32'h0;
        end
        w_allowin = (r_state == ST_RUN) & ~w_flush;
    end

    // Architectural side effects, suppressed when the instruction takes an exception.
    always_comb begin
        w_rf_we    = 1'b0;
        w_rf_waddr = 5'd0;
        w_rf_wdata = 32'h0;
        w_csr_ctrl = 80'h0;
        if (r_ws_valid) begin
            w_rf_we    = r_rf_we & ~w_ex;
            w_rf_waddr = r_rf_waddr;
            if (r_csr_re) begin
                w_rf_wdata = bus.csr_rvalue;
            end else begin
                w_rf_wdata = r_rf_wdata;
            end
            w_csr_ctrl = {r_csr_num, r_csr_re, r_csr_we & ~w_ex, r_csr_wvalue, r_csr_wmask};
        end else begin
            w_rf_we = 1'b0;
        end
    end

    assign bus.ws_allowin   = w_allowin;
    assign bus.csr_ctrl     = w_csr_ctrl;
    assign bus.csr_in_bus   = {w_ertn, w_ex, w_ecode, w_esubcode, w_pc};
    assign bus.flush        = w_flush;
    assign bus.flush_target = w_flush_target;
    assign bus.rf_we        = w_rf_we;
    assign bus.rf_waddr     = w_rf_waddr;
    assign bus.rf_wdata     = w_rf_wdata;
    assign bus.debug_wb_pc  = w_pc;

    // Instruction capture from MEM; the stage empties whenever nothing is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ws_valid   <= 1'b0;
            r_pc         <= 32'h0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= 32'h0;
            r_ex         <= 1'b0;
            r_ecode      <= 6'h00;
            r_esubcode   <= 9'h000;
            r_ertn       <= 1'b0;
            r_csr_num    <= 14'h0;
            r_csr_re     <= 1'b0;
            r_csr_we     <= 1'b0;
            r_csr_wvalue <= 32'h0;
            r_csr_wmask  <= 32'h0;
        end else if (bus.ms_valid && w_allowin) begin
            r_ws_valid   <= 1'b1;
            r_pc         <= bus.ms_pc;
            r_rf_we      <= bus.ms_rf_we;
            r_rf_waddr   <= bus.ms_rf_waddr;
            r_rf_wdata   <= bus.ms_rf_wdata;
            r_ex         <= bus.ms_ex;
            r_ecode      <= bus.ms_ecode;
            r_esubcode   <= bus.ms_esubcode;
            r_ertn       <= bus.ms_ertn;
            r_csr_num    <= bus.ms_csr_num;
            r_csr_re     <= bus.ms_csr_re;
            r_csr_we     <= bus.ms_csr_we;
            r_csr_wvalue <= bus.ms_csr_wvalue;
            r_csr_wmask  <= bus.ms_csr_wmask;
        end else begin
            r_ws_valid   <= 1'b0;
        end
    end

    // Run/drain control: after a flush the wrong-path MEM slot(s) are discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_flush) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= LP_DRAIN_LAST;
                    end else begin
                        r_state     <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 2'd0) begin
                        r_state     <= ST_RUN;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 2'd1;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_drain_cnt <= 2'd0;
                end
            endcase
        end
    end

    wb_commit_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .wb_ex      (w_ex),
        .ertn_flush (w_ertn),
        .flush      (w_flush),
        .allowin    (w_allowin)
    );

endmodule

// Invariants of the commit outputs.
module wb_commit_chk (
    input logic clk,
    input logic reset,
    input logic wb_ex,
    input logic ertn_flush,
    input logic flush,
    input logic allowin
);
    a_ex_ertn_excl: assert property (@(posedge clk) disable iff (reset) !(wb_ex && ertn_flush))
        else $error("wb_ex and ertn_flush high together");
    a_flush_src: assert property (@(posedge clk) disable iff (reset) flush == (wb_ex || ertn_flush))
        else $error("flush without a cause");
    a_flush_blocks: assert property (@(posedge clk) disable iff (reset) !(flush && allowin))
        else $error("allowin high during flush");
endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: directed scenarios plus a random instruction stream.
module tb_wb_commit;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam int         DRAIN_CYC = 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic        ertn;
        logic [13:0] csr_num;
        logic        re;
        logic        we;
        logic [31:0] wvalue;
        logic [31:0] wmask;
        logic        has_int;
        logic [31:0] ex_entry;
        logic [31:0] era_pc;
        logic [31:0] csr_rvalue;
    } op_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [79:0] csr_ctrl;
        logic [48:0] ibus;
        logic        flush;
        logic [31:0] target;
        logic [31:0] dbg;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_commit_if u_if ();

    wb_commit #(.ECODE_INT(ECODE_INT), .DRAIN_CYC(DRAIN_CYC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    int   n_checks = 0;
    int   n_pass = 0;
    int   n_commits = 0;
    int   m_drain = 0;
    exp_t sb_q[$];
    op_t  op_q[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic op_t blank_op();
        op_t o;
        o = '0;
        return o;
    endfunction

    // Reference behaviour of one committing instruction.
    function automatic exp_t predict(input op_t o);
        exp_t e;
        logic x;
        logic r;
        x = o.has_int | o.ex;
        r = o.ertn & ~x;
        e.rf_we    = o.rf_we & ~x;
        e.waddr    = o.waddr;
        e.wdata    = o.re ? o.csr_rvalue : o.wdata;
        e.csr_ctrl = {o.csr_num, o.re, o.we & ~x, o.wvalue, o.wmask};
        e.ibus     = {r, x, (o.has_int ? ECODE_INT : o.ecode), (o.has_int ? 9'h000 : o.esub), o.pc};
        e.flush    = x | r;
        e.target   = x ? o.ex_entry : (r ? o.era_pc : 32'h0);
        e.dbg      = o.pc;
        return e;
    endfunction

    function automatic op_t rand_op(input logic [31:0] pc);
        op_t o;
        o.pc         = pc;
        o.rf_we      = 1'($urandom_range(0, 1));
        o.waddr      = 5'($urandom);
        o.wdata      = $urandom;
        o.ex         = ($urandom_range(0, 7) == 0);
        o.ecode      = 6'($urandom);
        o.esub       = 9'($urandom);
        o.ertn       = ($urandom_range(0, 7) == 0);
        o.csr_num    = 14'($urandom);
        o.re         = 1'($urandom_range(0, 1));
        o.we         = 1'($urandom_range(0, 1));
        o.wvalue     = $urandom;
        o.wmask      = $urandom;
        o.has_int    = ($urandom_range(0, 9) == 0);
        o.ex_entry   = $urandom;
        o.era_pc     = $urandom;
        o.csr_rvalue = $urandom;
        return o;
    endfunction

    task automatic check_outputs(input exp_t e, input logic allow);
        check_eq("ws_allowin", u_if.ws_allowin, allow);
        check_eq("rf_we", u_if.rf_we, e.rf_we);
        check_eq("rf_waddr", u_if.rf_waddr, e.waddr);
        check_eq("rf_wdata", u_if.rf_wdata, e.wdata);
        check_eq("csr_ctrl", u_if.csr_ctrl, e.csr_ctrl);
        check_eq("csr_in_bus", u_if.csr_in_bus, e.ibus);
        check_eq("flush", u_if.flush, e.flush);
        check_eq("flush_target", u_if.flush_target, e.target);
        check_eq("debug_wb_pc", u_if.debug_wb_pc, e.dbg);
    endtask

    // One clock: set commit-side inputs for the op in WB, offer op to MEM, check, advance.
    task automatic cycle(input logic v, input op_t op);
        exp_t e;
        op_t  c;
        logic m_allow;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            c = op_q.pop_front();
            n_commits++;
        end else begin
            e = '0;
            c = rand_op(32'h0);
            c.has_int = 1'b1;
        end
        u_if.has_int    = c.has_int;
        u_if.ex_entry   = c.ex_entry;
        u_if.era_pc     = c.era_pc;
        u_if.csr_rvalue = c.csr_rvalue;
        u_if.ms_valid      = v;
        u_if.ms_pc         = op.pc;
        u_if.ms_rf_we      = op.rf_we;
        u_if.ms_rf_waddr   = op.waddr;
        u_if.ms_rf_wdata   = op.wdata;
        u_if.ms_ex         = op.ex;
        u_if.ms_ecode      = op.ecode;
        u_if.ms_esubcode   = op.esub;
        u_if.ms_ertn       = op.ertn;
        u_if.ms_csr_num    = op.csr_num;
        u_if.ms_csr_re     = op.re;
        u_if.ms_csr_we     = op.we;
        u_if.ms_csr_wvalue = op.wvalue;
        u_if.ms_csr_wmask  = op.wmask;
        m_allow = (m_drain == 0) && !e.flush;
        #1;
        check_outputs(e, m_allow);
        if (v && m_allow) begin
            sb_q.push_back(predict(op));
            op_q.push_back(op);
        end
        if (e.flush) begin
            m_drain = DRAIN_CYC;
        end else if (m_drain > 0) begin
            m_drain--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, blank_op());
        end
    endtask

    op_t o;
    exp_t z;
    int c0;

    initial begin
        o = blank_op();
        z = '0;
        u_if.ms_valid = 1'b0;
        u_if.has_int  = 1'b1;
        @(negedge clk);
        #1;
        check_outputs(z, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        idle(2);

        // ALU op
        o = blank_op(); o.pc = 32'h1c000000; o.rf_we = 1'b1; o.waddr = 5'd5; o.wdata = 32'h1234;
        cycle(1'b1, o); idle(1);
        // CSRRD
        o = blank_op(); o.pc = 32'h1c000004; o.rf_we = 1'b1; o.waddr = 5'd4; o.wdata = 32'h5555;
        o.csr_num = 14'h5; o.re = 1'b1; o.csr_rvalue = 32'hABCD;
        cycle(1'b1, o); idle(1);
        // SYSCALL followed by wrong-path instructions offered every cycle
        o = blank_op(); o.pc = 32'h1c000040; o.ex = 1'b1; o.ecode = 6'hB; o.rf_we = 1'b1;
        o.waddr = 5'd7; o.ex_entry = 32'h1c008000;
        cycle(1'b1, o);
        for (int i = 0; i < 4; i++) begin
            o = blank_op(); o.pc = 32'h1c000044 + 32'(4 * i); o.rf_we = 1'b1; o.waddr = 5'd9;
            cycle(1'b1, o);
        end
        idle(1);
        // ERTN
        o = blank_op(); o.pc = 32'h1c000080; o.ertn = 1'b1; o.era_pc = 32'h1c000044;
        o.ex_entry = 32'h1c008000;
        cycle(1'b1, o); idle(2);
        // ERTN that also carries an exception: exception wins
        o = blank_op(); o.pc = 32'h1c000090; o.ertn = 1'b1; o.ex = 1'b1; o.ecode = 6'h3;
        o.ex_entry = 32'h1c00a000; o.era_pc = 32'h1c000100;
        cycle(1'b1, o); idle(2);
        // CSRWR with interrupt pending
        o = blank_op(); o.pc = 32'h1c0000a0; o.csr_num = 14'h6; o.we = 1'b1; o.re = 1'b1;
        o.wvalue = 32'hDEAD; o.wmask = 32'hFFFF; o.rf_we = 1'b1; o.waddr = 5'd3;
        o.has_int = 1'b1; o.ecode = 6'h2A; o.esub = 9'h1F; o.ex_entry = 32'h1c00c000;
        cycle(1'b1, o); idle(2);
        // write to r0 passes through
        o = blank_op(); o.pc = 32'h1c0000b0; o.rf_we = 1'b1; o.waddr = 5'd0; o.wdata = 32'hFFFF_FFFF;
        cycle(1'b1, o); idle(1);

        // reset during DRAIN
        o = blank_op(); o.pc = 32'h1c0000c0; o.ex = 1'b1; o.ecode = 6'hB; o.ex_entry = 32'h1c008000;
        cycle(1'b1, o);
        cycle(1'b0, blank_op());
        check_eq("drain_allowin", u_if.ws_allowin, 1'b0);
        reset = 1'b1;
        #1;
        check_outputs(z, 1'b1);
        sb_q.delete();
        op_q.delete();
        m_drain = 0;
        @(negedge clk);
        reset = 1'b0;
        c0 = n_commits;
        for (int i = 0; i < 4; i++) begin
            o = blank_op(); o.pc = 32'h1c000200 + 32'(4 * i); o.rf_we = 1'b1;
            o.waddr = 5'(i + 10); o.wdata = 32'(i * 17 + 3);
            cycle(1'b1, o);
        end
        cycle(1'b0, blank_op());
        check_eq("b2b_commits", 32'(n_commits - c0), 32'd4);
        idle(1);

        // random stream with sporadic bubbles
        for (int i = 0; i < 60; i++) begin
            cycle(($urandom_range(0, 3) != 0), rand_op(32'h1c010000 + 32'(4 * i)));
        end
        idle(3);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
